// File: rtl/sirv_debug_ram_arb_pkg.sv
// Shared definitions for the debug RAM arbiter: RAM geometry and port-id encoding.
package sirv_debug_ram_arb_pkg;

   localparam int RAM_WORDS = 7;
   localparam int IDX_W     = 3;
   localparam int DATA_W    = 32;

   // Highest implemented word index; anything above it is out of range.
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_WORDS - 1);

   typedef enum logic {
      PORT_DM   = 1'b0,
      PORT_HART = 1'b1
   } port_e;

endpackage

// File: rtl/sirv_debug_ram_arb_rsp_slot.sv
// One-entry response register: captures a response on load, holds it until the consumer
// takes it with rsp_ready. A load in the draining cycle replaces the old entry.
module sirv_debug_ram_rsp_slot
   import sirv_debug_ram_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_rdata,
   input  logic              load_err,
   input  logic              rsp_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the always blocks are evaluated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (load) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= load_rdata;
         rsp_err   <= load_err;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sirv_debug_ram_arb.sv
// Round-robin arbiter putting the DM and hart command ports onto the single debug RAM port.
// Define SIRV_DBGRAM_ERR_EN to flag out-of-range and misaligned accesses through rsp_err.
module sirv_debug_ram_arb
   import sirv_debug_ram_arb_pkg::*;
#(
   parameter int HART_AW = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               dm_cmd_valid,
   output logic               dm_cmd_ready,
   input  logic               dm_cmd_read,
   input  logic [IDX_W-1:0]   dm_cmd_addr,
   input  logic [DATA_W-1:0]  dm_cmd_wdata,
   output logic               dm_rsp_valid,
   input  logic               dm_rsp_ready,
   output logic [DATA_W-1:0]  dm_rsp_rdata,
   output logic               dm_rsp_err,
   input  logic               hart_cmd_valid,
   output logic               hart_cmd_ready,
   input  logic               hart_cmd_read,
   input  logic [HART_AW-1:0] hart_cmd_addr,
   input  logic [DATA_W-1:0]  hart_cmd_wdata,
   output logic               hart_rsp_valid,
   input  logic               hart_rsp_ready,
   output logic [DATA_W-1:0]  hart_rsp_rdata,
   output logic               hart_rsp_err,
   output logic               ram_cs,
   output logic               ram_rd,
   output logic [IDX_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]  ram_wdat,
   input  logic [DATA_W-1:0]  ram_dout
);

   port_e             rr_q, rr_d;
   logic              dm_elig, hart_elig;
   logic              grant_dm, grant_hart;
   logic              sel_read, bad_access, rsp_err;
   logic [IDX_W-1:0]  sel_idx;
   logic [DATA_W-1:0] sel_wdata, rsp_rdata;

   // Only the word-index bits (and, with error checking, [1:0]) of the hart address matter.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{hart_cmd_addr[HART_AW-1:5], hart_cmd_addr[1:0]};

   // A response slot frees in the same cycle it drains, so back-to-back accepts need rsp_ready.
   assign dm_elig   = dm_cmd_valid   & (~dm_rsp_valid   | dm_rsp_ready);
   assign hart_elig = hart_cmd_valid & (~hart_rsp_valid | hart_rsp_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_q <= PORT_HART;
      else        rr_q <= rr_d;
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      grant_hart = 1'b0;
      grant_dm   = 1'b0;
      rr_d       = rr_q;
      if (hart_elig && (!dm_elig || rr_q == PORT_HART)) begin
         grant_hart = 1'b1;
         rr_d       = PORT_DM;
      end else if (dm_elig) begin
         grant_dm = 1'b1;
         rr_d     = PORT_HART;
      end
   end

   assign dm_cmd_ready   = grant_dm;
   assign hart_cmd_ready = grant_hart;

   assign sel_read  = grant_hart ? hart_cmd_read      : dm_cmd_read;
   assign sel_idx   = grant_hart ? hart_cmd_addr[4:2] : dm_cmd_addr;
   assign sel_wdata = grant_hart ? hart_cmd_wdata     : dm_cmd_wdata;

`ifdef SIRV_DBGRAM_ERR_EN
   assign bad_access = (sel_idx > LAST_IDX) | (grant_hart & (|hart_cmd_addr[1:0]));
   assign rsp_err    = bad_access;
`else
   assign bad_access = (sel_idx > LAST_IDX);
   assign rsp_err    = 1'b0;
`endif

   // Rejected accesses never reach the RAM but are still accepted and answered.
   assign ram_cs    = (grant_dm | grant_hart) & ~bad_access;
   assign ram_rd    = sel_read;
   assign ram_addr  = sel_idx;
   assign ram_wdat  = sel_wdata;
   assign rsp_rdata = (sel_read && !bad_access) ? ram_dout : '0;

   sirv_debug_ram_rsp_slot u_dm_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (grant_dm),
      .load_rdata (rsp_rdata),
      .load_err   (rsp_err),
      .rsp_ready  (dm_rsp_ready),
      .rsp_valid  (dm_rsp_valid),
      .rsp_rdata  (dm_rsp_rdata),
      .rsp_err    (dm_rsp_err)
   );

   sirv_debug_ram_rsp_slot u_hart_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (grant_hart),
      .load_rdata (rsp_rdata),
      .load_err   (rsp_err),
      .rsp_ready  (hart_rsp_ready),
      .rsp_valid  (hart_rsp_valid),
      .rsp_rdata  (hart_rsp_rdata),
      .rsp_err    (hart_rsp_err)
   );

endmodule
